// File: rtl/line_memory_ctrl.sv
// rtl/line_memory_ctrl.sv - fixed-latency single-port line memory controller
//
// Accepts one full-line read or write request at a time. The request is
// latched, held for LATENCY cycles in WAIT, and then the array is accessed on
// the edge that enters ACK. ACK lasts one cycle and always returns to IDLE.
//
// Optional feature macro: LINE_MEMORY_STATS_EN adds completed read/write
// counters; without it rd_cnt_o/wr_cnt_o are tied to zero.
//
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-low reset
//   enable_i  : request valid, held until ack_o
//   write_i   : 1 = write line, 0 = read line
//   addr_i    : byte address, line index = addr_i[ADDR_W-1:OFF]
//   data_i    : write line data
//   ack_o     : one-cycle completion pulse
//   data_o    : read line data, holds its value between reads
//   busy_o    : request in flight (WAIT or ACK)
//   err_o     : out-of-range index, coincident with ack_o
//   rd_cnt_o  : completed reads
//   wr_cnt_o  : completed writes
`timescale 1ns/1ps
module line_memory_ctrl #(
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o
);

  localparam int OFF    = $clog2(LINE_W / 8);
  localparam int IDX_W  = ADDR_W - OFF;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [7:0]     LAST_CNT = 8'(LATENCY - 1);
  // One extra bit so DEPTH itself is representable in the range compare.
  localparam logic [IDX_W:0] DEPTH_L  = (IDX_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic              write_q;
  logic              accept;
  logic              access;
  logic              in_range;

  logic [LINE_W-1:0] memory [DEPTH];

  // Byte-offset bits inside a line do not select anything.
  generate
    if (OFF > 0) begin : g_offset
      logic unused_offset_bits;
      assign unused_offset_bits = ^addr_i[OFF-1:0];
    end
  endgenerate

  assign in_range = ({1'b0, idx_q} < DEPTH_L);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    access  = 1'b0;
    ack_o   = 1'b0;
    busy_o  = 1'b0;
    err_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        busy_o = 1'b1;
        if (cnt_q == LAST_CNT) begin
          access  = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        // enable_i is deliberately ignored here; a held request is
        // re-accepted only from the following IDLE cycle.
        busy_o  = 1'b1;
        ack_o   = 1'b1;
        err_o   = ~in_range;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      data_o  <= '0;
    end else begin
      if (accept) begin
        cnt_q   <= '0;
        idx_q   <= addr_i[ADDR_W-1:OFF];
        wdata_q <= data_i;
        write_q <= write_i;
      end else if ((state_q == WAIT) && !access) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (access && !write_q) begin
        data_o <= in_range ? memory[idx_q[MEM_AW-1:0]] : '0;
      end
    end
  end

  // No reset on the array: contents survive reset, and an aborted request
  // never reaches this write because reset forces the FSM out of WAIT.
  always_ff @(posedge clk_i) begin
    if (access && write_q && in_range) begin
      memory[idx_q[MEM_AW-1:0]] <= wdata_q;
    end
  end

`ifdef LINE_MEMORY_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (state_q == ACK) begin
      if (write_q) begin
        wr_cnt_q <= wr_cnt_q + 32'd1;
      end else begin
        rd_cnt_q <= rd_cnt_q + 32'd1;
      end
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`else
  assign rd_cnt_o = '0;
  assign wr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_line_memory_ctrl.sv
// tb/tb_line_memory_ctrl.sv - self-checking bench for line_memory_ctrl
`timescale 1ns/1ps
module tb_line_memory_ctrl;

  localparam int LW = 256;

`ifdef LINE_MEMORY_STATS_EN
  localparam int EXP_RD = 6;
  localparam int EXP_WR = 3;
`else
  localparam int EXP_RD = 0;
  localparam int EXP_WR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;

  logic          en, wr;
  logic [31:0]   addr;
  logic [LW-1:0] din;
  logic          ack, busy, err;
  logic [LW-1:0] dout;
  logic [31:0]   rdc, wrc;

  logic          en3, wr3;
  logic [31:0]   addr3;
  logic [LW-1:0] din3;
  logic          ack3, busy3, err3;
  logic [LW-1:0] dout3;
  logic [31:0]   rdc3, wrc3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_memory_ctrl u_dut (
    .clk_i(clk), .rst_i(rst_n), .enable_i(en), .write_i(wr), .addr_i(addr),
    .data_i(din), .ack_o(ack), .data_o(dout), .busy_o(busy), .err_o(err),
    .rd_cnt_o(rdc), .wr_cnt_o(wrc)
  );

  line_memory_ctrl #(.LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst_n), .enable_i(en3), .write_i(wr3), .addr_i(addr3),
    .data_i(din3), .ack_o(ack3), .data_o(dout3), .busy_o(busy3), .err_o(err3),
    .rd_cnt_o(rdc3), .wr_cnt_o(wrc3)
  );

  typedef struct {
    logic          wr;
    logic [31:0]   addr;
    logic [LW-1:0] data;
    logic [LW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  typedef struct {
    logic [LW-1:0] data;
    logic          err;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [LW-1:0] d,
                              input logic [LW-1:0] ed, input logic ee);
    vec_t v;
    v.wr = w; v.addr = a; v.data = d; v.exp_data = ed; v.exp_err = ee;
    return v;
  endfunction

  // Issue one request on u_dut, scramble inputs during WAIT, and compare the
  // ack timing plus the scoreboard entry when ack_o arrives.
  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int   n;
    bit   seen;
    @(negedge clk);
    en = 1'b1; wr = v.wr; addr = v.addr; din = v.data;
    e.data = v.exp_data; e.err = v.exp_err;
    sb.push_back(e);
    @(posedge clk);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk($sformatf("vec%0d busy_wait", idx), busy, 1);
        wr = ~wr; addr = $urandom; din = {8{$urandom}};
      end
      if (ack) seen = 1'b1;
    end
    chk($sformatf("vec%0d ack_latency", idx), n, 11);
    if (seen) begin
      e = sb.pop_front();
      chk($sformatf("vec%0d data_o", idx), dout, e.data);
      chk($sformatf("vec%0d err_o", idx), err, e.err);
    end
    en = 1'b0;
    @(negedge clk);
    chk($sformatf("vec%0d ack_single", idx), ack, 0);
    chk($sformatf("vec%0d busy_idle", idx), busy, 0);
  endtask

  initial begin
    int first_ack, last_ack, n_ack, bad_spacing;

    en = 0; wr = 0; addr = '0; din = '0;
    en3 = 0; wr3 = 0; addr3 = '0; din3 = '0;
    u_dut.memory[0] = 256'h5;
    u_dut.memory[2] = 256'h77;

    repeat (2) @(negedge clk);
    chk("rst ack_o", ack, 0);
    chk("rst busy_o", busy, 0);
    chk("rst err_o", err, 0);
    chk("rst data_o", dout, 0);
    chk("rst rd_cnt_o", rdc, 0);
    chk("rst wr_cnt_o", wrc, 0);
    rst_n = 1'b1;

    vecs[0] = mk(1'b0, 32'h0000, '0,           256'h5,        1'b0);
    vecs[1] = mk(1'b1, 32'h0020, 256'hABCD,    256'h5,        1'b0);
    vecs[2] = mk(1'b0, 32'h0020, '0,           256'hABCD,     1'b0);
    vecs[3] = mk(1'b1, 32'h3FE0, 256'hDEADBEEF, 256'hABCD,    1'b0);
    vecs[4] = mk(1'b0, 32'h3FE0, '0,           256'hDEADBEEF, 1'b0);
    vecs[5] = mk(1'b0, 32'h4000, '0,           256'h0,        1'b1);
    vecs[6] = mk(1'b1, 32'h4000, 256'hFFFF,    256'h0,        1'b1);
    vecs[7] = mk(1'b0, 32'h0000, '0,           256'h5,        1'b0);
    vecs[8] = mk(1'b0, 32'h003F, '0,           256'hABCD,     1'b0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    chk("mem[0] untouched", u_dut.memory[0], 256'h5);
    chk("mem[1] written", u_dut.memory[1], 256'hABCD);
    chk("mem[511] written", u_dut.memory[511], 256'hDEADBEEF);
    chk("mem[2] untouched", u_dut.memory[2], 256'h77);
    chk("stats rd_cnt_o", rdc, EXP_RD);
    chk("stats wr_cnt_o", wrc, EXP_WR);

    // Reset in the 4th WAIT cycle of a write to line 2.
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = 32'h40; din = 256'h1234;
    @(posedge clk);
    repeat (4) @(negedge clk);
    chk("abort busy before reset", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort busy_o", busy, 0);
    chk("abort ack_o", ack, 0);
    chk("abort data_o", dout, 0);
    chk("abort rd_cnt_o", rdc, 0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_ack = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (ack) n_ack++;
    end
    chk("abort no ack", n_ack, 0);
    chk("abort mem[2]", u_dut.memory[2], 256'h77);

    // LATENCY=3 instance with enable held for 30 cycles.
    @(negedge clk);
    en3 = 1'b1; wr3 = 1'b1; addr3 = 32'h0; din3 = 256'h9;
    first_ack = -1; last_ack = -1; n_ack = 0; bad_spacing = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (ack3) begin
        if (first_ack < 0) first_ack = c;
        if (last_ack >= 0 && (c - last_ack) != 5) bad_spacing++;
        last_ack = c;
        n_ack++;
      end
    end
    en3 = 1'b0;
    chk("lat3 first ack", first_ack, 4);
    chk("lat3 ack count", n_ack, 6);
    chk("lat3 spacing", bad_spacing, 0);
    repeat (6) @(negedge clk);
    chk("lat3 idle busy", busy3, 0);
    chk("lat3 mem[0]", u_dut3.memory[0], 256'h9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_memory_ctrl.md
LINE_MEMORY_CTRL -- requirements
Module: line_memory_ctrl

Interface
REQ-001 SHALL have parameter LINE_W, default 256, meaning bits per memory line.
REQ-002 SHALL have parameter DEPTH, default 512, meaning number of lines.
REQ-003 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-004 SHALL have parameter LATENCY, default 10, meaning cycles from accept to ack (legal range 1..255).
REQ-005 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port enable_i, input, 1, request valid; held high by the requester until ack_o.
REQ-008 SHALL have port write_i, input, 1, 1=write line, 0=read line.
REQ-009 SHALL have port addr_i, input, ADDR_W, byte address; line index = addr_i[ADDR_W-1:OFF], OFF = log2(LINE_W/8).
REQ-010 SHALL have port data_i, input, LINE_W, write line data.
REQ-011 SHALL have port ack_o, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port data_o, output, LINE_W, read line data.
REQ-013 SHALL have port busy_o, output, 1, high while a request is in flight.
REQ-014 SHALL have port err_o, output, 1, out-of-range pulse coincident with ack_o.
REQ-015 SHALL have ports rd_cnt_o and wr_cnt_o, output, 32 each, completed read/write counters.

Function
REQ-016 SHALL implement the FSM IDLE -> WAIT -> ACK -> IDLE, with state encoding IDLE=0, WAIT=1, ACK=2.
REQ-017 In IDLE with enable_i=1, SHALL latch addr_i, data_i and write_i, clear the cycle counter, and enter WAIT.
REQ-018 In WAIT, SHALL increment the counter each cycle and ignore all input changes.
REQ-019 When the counter reaches LATENCY-1, SHALL perform the array access and enter ACK.
REQ-020 In ACK, SHALL drive ack_o=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-021 enable_i still high during ACK SHALL NOT start a new request; a new request is accepted at the earliest in the following IDLE cycle.
REQ-022 Accept-to-ack latency SHALL be exactly LATENCY+1 cycles after the accepting edge; back-to-back requests SHALL be spaced LATENCY+2 cycles.
REQ-023 On a read, data_o SHALL be updated with the array line when the FSM enters ACK; data_o SHALL otherwise hold its last value, including across writes.
REQ-024 On a write, the array line SHALL be written with the latched data when the FSM enters ACK; the write is full-line only.
REQ-025 If the line index is >= DEPTH, a write SHALL be dropped, a read SHALL return all zeros, and err_o SHALL be 1 in the ACK cycle.
REQ-026 busy_o SHALL be 1 in WAIT and ACK, and 0 in IDLE.
REQ-027 With LATENCY=1, the FSM SHALL spend exactly one cycle in WAIT.
REQ-028 The array SHALL remain hierarchically accessible as a memory named "memory" so benches can preload and inspect it.

Reset
REQ-029 With rst_i low, SHALL force the state to IDLE and the counter, ack_o, err_o, busy_o and data_o to 0, asynchronously.
REQ-030 Reset asserted mid-request SHALL abort the request without writing the array.
REQ-031 Reset SHALL NOT clear array contents.

Configuration
REQ-032 Macro LINE_MEMORY_STATS_EN defined: rd_cnt_o and wr_cnt_o SHALL reset to 0 and each SHALL increment by 1 in the ACK cycle of every completed read or write respectively, out-of-range requests included, wrapping at 2^32.
REQ-033 Macro LINE_MEMORY_STATS_EN undefined: rd_cnt_o and wr_cnt_o SHALL be constant 0 and no counter registers SHALL exist.

Verification
REQ-034 Preload memory[0]=256'h5, read addr 0x0 with LATENCY=10 -> ack_o high on the 11th cycle after accept, data_o=256'h5, err_o=0.
REQ-035 Write addr 0x20 with data_i=256'hABCD, then read 0x20 -> second ack returns 256'hABCD; memory[1]=256'hABCD.
REQ-036 Hold enable_i high for 30 cycles with LATENCY=3 -> ack pulses exactly every 5 cycles, each one cycle wide.
REQ-037 Read addr 0x4000 with DEPTH=512 -> data_o=0 and err_o=1 with ack_o; a write to the same address leaves all lines unchanged.
REQ-038 Assert rst_i low in the 4th WAIT cycle of a write -> ack_o never pulses, target line unchanged, busy_o=0 immediately.
REQ-039 With LINE_MEMORY_STATS_EN defined, run 3 reads and 2 writes -> rd_cnt_o=3, wr_cnt_o=2; with the macro undefined -> both counters read 0.
